// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants, counter widths and sync bundle type.
package vga_pkg;
  localparam int HCNT_W = 10;
  localparam int VCNT_W = 10;
  localparam int POSY_W = 9;
  localparam int DEF_H_VIS = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_VIS = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } sync_t;
  function automatic int h_total(int vis, int fp, int sync, int bp);
    return vis + fp + sync + bp;
  endfunction
  function automatic int v_total(int vis, int fp, int sync, int bp);
    return vis + fp + sync + bp;
  endfunction
endpackage

// File: rtl/vga_if.sv
// vga_if: raster outputs plus the pixel-rate enable between the timing generator and its consumers.
interface vga_if;
  import vga_pkg::*;
  logic pix_en;
  logic [HCNT_W-1:0] posx;
  logic [POSY_W-1:0] posy;
  logic hsync;
  logic vsync;
  logic active;
  logic line_start;
  logic frame_start;
  modport master (input pix_en, output posx, posy, hsync, vsync, active, line_start, frame_start);
  modport slave (output pix_en, input posx, posy, hsync, vsync, active, line_start, frame_start);
endinterface

// File: rtl/vga_timing_sync_delay.sv
// sync_delay: enable-gated 3-bit shift register with per-bit reset values.
// Stage 0 is the decode register that sits alongside posx/posy.
module sync_delay #(
  parameter int DEPTH = 1,
  parameter logic [2:0] RST_VAL = 3'b000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [2:0] i_d,
  output logic [2:0] o_q
);
  logic [2:0] r_sr [DEPTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_sr[k] <= RST_VAL;
    end else if (i_en) begin
      r_sr[0] <= i_d;
      for (int k = 1; k < DEPTH; k++) r_sr[k] <= r_sr[k-1];
    end
  assign o_q = r_sr[DEPTH-1];
endmodule

// File: rtl/vga_timing.sv
// vga_timing: pixel-enable raster generator producing posx/posy for the bitmap
// reader and pipeline-matched hsync/vsync/active for the DAC side.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VIS    = DEF_H_VIS,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_VIS    = DEF_V_VIS,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int PIPE_DLY = 2
) (
  input logic clk,
  input logic rst_n,
  vga_if.master vga
);
  localparam int H_TOTAL = h_total(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_VIS, V_FP, V_SYNC, V_BP);
  localparam sync_t IDLE = '{act: 1'b0, hs: !H_POL, vs: !V_POL};
  generate
    if (H_VIS > 1024 || V_VIS > 512 || PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_bad_param
      $error("vga_timing: H_VIS<=1024, V_VIS<=512 and PIPE_DLY in 0..4 required");
    end
  endgenerate
  logic [HCNT_W-1:0] r_hcnt, w_hnext, r_posx;
  logic [VCNT_W-1:0] r_vcnt, w_vnext;
  logic [POSY_W-1:0] r_posy;
  logic r_line_start, r_frame_start, w_hwrap, w_hvis, w_vvis;
  sync_t w_dec, w_dly;
  // Everything registered is decoded from the next count, so outputs describe the period starting at this edge.
  always_comb begin
    w_hwrap = int'(r_hcnt) == H_TOTAL - 1;
    w_hnext = w_hwrap ? '0 : r_hcnt + HCNT_W'(1);
    w_vnext = !w_hwrap ? r_vcnt : int'(r_vcnt) == V_TOTAL - 1 ? '0 : r_vcnt + VCNT_W'(1);
    w_hvis = int'(w_hnext) < H_VIS;
    w_vvis = int'(w_vnext) < V_VIS;
    w_dec.act = w_hvis && w_vvis;
    w_dec.hs = (int'(w_hnext) >= H_VIS + H_FP && int'(w_hnext) < H_VIS + H_FP + H_SYNC) ? H_POL : !H_POL;
    w_dec.vs = (int'(w_vnext) >= V_VIS + V_FP && int'(w_vnext) < V_VIS + V_FP + V_SYNC) ? V_POL : !V_POL;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_hcnt <= HCNT_W'(H_TOTAL - 1);
      r_vcnt <= VCNT_W'(V_TOTAL - 1);
      r_posx <= '0;
      r_posy <= '0;
      r_line_start <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start <= vga.pix_en && w_hnext == '0;
      r_frame_start <= vga.pix_en && w_hnext == '0 && w_vnext == '0;
      if (vga.pix_en) begin
        r_hcnt <= w_hnext;
        r_vcnt <= w_vnext;
        r_posx <= w_hvis ? w_hnext : '0;
        r_posy <= w_vvis ? w_vnext[POSY_W-1:0] : '0;
      end
    end
  sync_delay #(.DEPTH(PIPE_DLY + 1), .RST_VAL(IDLE)) u_sync_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .i_en (vga.pix_en),
    .i_d  (w_dec),
    .o_q  (w_dly)
  );
  assign vga.posx = r_posx;
  assign vga.posy = r_posy;
  assign vga.line_start = r_line_start;
  assign vga.frame_start = r_frame_start;
  assign vga.active = w_dly.act;
  assign vga.hsync = w_dly.hs;
  assign vga.vsync = w_dly.vs;
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed checks on a default 640x480 instance (PIPE_DLY=2)
// and a miniature 16x12-total instance (PIPE_DLY=0) that makes whole frames cheap.
module tb_vga_timing;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int n_checks = 0;
  int n_errors = 0;
  vga_if bus_a ();
  vga_if bus_b ();
  vga_timing #(.PIPE_DLY(2)) dut_a (.clk(clk), .rst_n(rst_a), .vga(bus_a));
  vga_timing #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .PIPE_DLY(0)
  ) dut_b (.clk(clk), .rst_n(rst_b), .vga(bus_b));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_a;
    rst_a = 1'b0;
    bus_a.pix_en = 1'b0;
    tick();
    rst_a = 1'b1;
  endtask

  task automatic start_b;
    rst_b = 1'b0;
    bus_b.pix_en = 1'b0;
    tick();
    rst_b = 1'b1;
  endtask

  task automatic test_reset;
    rst_a = 1'b0; rst_b = 1'b0;
    bus_a.pix_en = 1'b1; bus_b.pix_en = 1'b1;
    tick(); tick();
    n_checks++;
    if ({bus_a.posx, bus_a.posy, bus_a.active, bus_a.hsync, bus_a.vsync, bus_a.line_start, bus_a.frame_start} !== {10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_errors++; $display("FAIL reset_a: got posx=%0d posy=%0d act=%b hs=%b vs=%b ls=%b fs=%b want 0 0 0 1 1 0 0", bus_a.posx, bus_a.posy, bus_a.active, bus_a.hsync, bus_a.vsync, bus_a.line_start, bus_a.frame_start);
    end
    n_checks++;
    if ({bus_b.posx, bus_b.posy, bus_b.active, bus_b.hsync, bus_b.vsync, bus_b.line_start, bus_b.frame_start} !== {10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_errors++; $display("FAIL reset_b: got posx=%0d posy=%0d act=%b hs=%b vs=%b ls=%b fs=%b want 0 0 0 1 1 0 0", bus_b.posx, bus_b.posy, bus_b.active, bus_b.hsync, bus_b.vsync, bus_b.line_start, bus_b.frame_start);
    end
  endtask

  task automatic test_first_edge;
    rst_b = 1'b1;
    tick();
    n_checks++;
    if ({bus_b.posx, bus_b.posy, bus_b.active, bus_b.line_start, bus_b.frame_start} !== {10'd0, 9'd0, 3'b111}) begin
      n_errors++; $display("FAIL first_edge: got posx=%0d posy=%0d act=%b ls=%b fs=%b want 0 0 1 1 1", bus_b.posx, bus_b.posy, bus_b.active, bus_b.line_start, bus_b.frame_start);
    end
    tick();
    n_checks++;
    if ({bus_b.posx, bus_b.active, bus_b.line_start, bus_b.frame_start} !== {10'd1, 3'b100}) begin
      n_errors++; $display("FAIL second_edge: got posx=%0d act=%b ls=%b fs=%b want 1 1 0 0", bus_b.posx, bus_b.active, bus_b.line_start, bus_b.frame_start);
    end
  endtask

  task automatic test_frame;
    int hs_cnt = 0, hs_first = -1, vs_cnt = 0, vs_first = -1;
    int act_cnt = 0, ls_cnt = 0, fs_cnt = 0, blank_posy = 0;
    int x87 = -1, y87 = -1, x88 = -1;
    start_b();
    bus_b.pix_en = 1'b1;
    for (int t = 0; t < 192; t++) begin
      tick();
      if (!bus_b.hsync) begin hs_cnt++; if (hs_first < 0) hs_first = t; end
      if (!bus_b.vsync) begin vs_cnt++; if (vs_first < 0) vs_first = t; end
      if (bus_b.active) act_cnt++;
      if (bus_b.line_start) ls_cnt++;
      if (bus_b.frame_start) fs_cnt++;
      if (t >= 96 && bus_b.posy != 0) blank_posy++;
      if (t == 87) begin x87 = int'(bus_b.posx); y87 = int'(bus_b.posy); end
      if (t == 88) x88 = int'(bus_b.posx);
    end
    n_checks++; if (hs_cnt !== 36) begin n_errors++; $display("FAIL frame_hs_count: got %0d want 36", hs_cnt); end
    n_checks++; if (hs_first !== 10) begin n_errors++; $display("FAIL frame_hs_first: got %0d want 10", hs_first); end
    n_checks++; if (vs_cnt !== 32) begin n_errors++; $display("FAIL frame_vs_count: got %0d want 32", vs_cnt); end
    n_checks++; if (vs_first !== 128) begin n_errors++; $display("FAIL frame_vs_first: got %0d want 128", vs_first); end
    n_checks++; if (act_cnt !== 48) begin n_errors++; $display("FAIL frame_active_count: got %0d want 48", act_cnt); end
    n_checks++; if (ls_cnt !== 12) begin n_errors++; $display("FAIL frame_ls_count: got %0d want 12", ls_cnt); end
    n_checks++; if (fs_cnt !== 1) begin n_errors++; $display("FAIL frame_fs_count: got %0d want 1", fs_cnt); end
    n_checks++; if (blank_posy !== 0) begin n_errors++; $display("FAIL frame_vblank_posy: got %0d nonzero want 0", blank_posy); end
    n_checks++; if (x87 !== 7 || y87 !== 5) begin n_errors++; $display("FAIL frame_last_pixel: got (%0d,%0d) want (7,5)", x87, y87); end
    n_checks++; if (x88 !== 0) begin n_errors++; $display("FAIL frame_hblank_posx: got %0d want 0", x88); end
    tick();
    n_checks++;
    if ({bus_b.frame_start, bus_b.posx, bus_b.posy} !== {1'b1, 10'd0, 9'd0}) begin
      n_errors++; $display("FAIL frame_period: got fs=%b posx=%0d posy=%0d want 1 0 0", bus_b.frame_start, bus_b.posx, bus_b.posy);
    end
  endtask

  task automatic test_pix_en_toggle;
    logic [21:0] prev;
    int hold_bad = 0, ls_cnt = 0, fs_cnt = 0, ls2 = -1;
    start_b();
    prev = '0;
    for (int c = 0; c < 100; c++) begin
      bus_b.pix_en = (c % 2 == 0);
      tick();
      if (!bus_b.pix_en && ({bus_b.posx, bus_b.posy, bus_b.hsync, bus_b.vsync, bus_b.active} !== prev || bus_b.line_start || bus_b.frame_start)) hold_bad++;
      if (bus_b.line_start) begin ls_cnt++; if (ls_cnt == 2) ls2 = c; end
      if (bus_b.frame_start) fs_cnt++;
      prev = {bus_b.posx, bus_b.posy, bus_b.hsync, bus_b.vsync, bus_b.active};
    end
    n_checks++; if (hold_bad !== 0) begin n_errors++; $display("FAIL toggle_hold: got %0d bad idle cycles want 0", hold_bad); end
    n_checks++; if (ls2 !== 32) begin n_errors++; $display("FAIL toggle_line_period: got second ls at clk %0d want 32", ls2); end
    n_checks++; if (ls_cnt !== 4) begin n_errors++; $display("FAIL toggle_ls_count: got %0d want 4", ls_cnt); end
    n_checks++; if (fs_cnt !== 1) begin n_errors++; $display("FAIL toggle_fs_count: got %0d want 1", fs_cnt); end
  endtask

  task automatic test_pipe_delay;
    int hold_bad = 0;
    start_a();
    bus_a.pix_en = 1'b1;
    tick();
    n_checks++; if (bus_a.active !== 1'b0) begin n_errors++; $display("FAIL pipe_t0_active: got %b want 0", bus_a.active); end
    bus_a.pix_en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus_a.active !== 1'b0 || bus_a.posx !== 10'd0) hold_bad++;
    end
    n_checks++; if (hold_bad !== 0) begin n_errors++; $display("FAIL pipe_hold: got %0d bad idle cycles want 0", hold_bad); end
    bus_a.pix_en = 1'b1;
    tick();
    n_checks++; if ({bus_a.posx, bus_a.active} !== {10'd1, 1'b0}) begin n_errors++; $display("FAIL pipe_t1: got posx=%0d act=%b want 1 0", bus_a.posx, bus_a.active); end
    tick();
    n_checks++; if ({bus_a.posx, bus_a.active} !== {10'd2, 1'b1}) begin n_errors++; $display("FAIL pipe_t2: got posx=%0d act=%b want 2 1", bus_a.posx, bus_a.active); end
  endtask

  task automatic test_line;
    int hs_cnt = 0, hs_first = -1, hs_last = -1, act_cnt = 0, act_first = -1, act_last = -1;
    int ls_cnt = 0, vs_cnt = 0, blank_posx = 0, x639 = -1;
    start_a();
    bus_a.pix_en = 1'b1;
    for (int t = 0; t < 800; t++) begin
      tick();
      if (!bus_a.hsync) begin hs_cnt++; hs_last = t; if (hs_first < 0) hs_first = t; end
      if (bus_a.active) begin act_cnt++; act_last = t; if (act_first < 0) act_first = t; end
      if (bus_a.line_start) ls_cnt++;
      if (!bus_a.vsync) vs_cnt++;
      if (t >= 640 && bus_a.posx != 0) blank_posx++;
      if (t == 639) x639 = int'(bus_a.posx);
    end
    n_checks++; if (hs_first !== 658) begin n_errors++; $display("FAIL line_hs_first: got %0d want 658", hs_first); end
    n_checks++; if (hs_last !== 753) begin n_errors++; $display("FAIL line_hs_last: got %0d want 753", hs_last); end
    n_checks++; if (hs_cnt !== 96) begin n_errors++; $display("FAIL line_hs_count: got %0d want 96", hs_cnt); end
    n_checks++; if (act_first !== 2 || act_last !== 641) begin n_errors++; $display("FAIL line_active_span: got %0d..%0d want 2..641", act_first, act_last); end
    n_checks++; if (act_cnt !== 640) begin n_errors++; $display("FAIL line_active_count: got %0d want 640", act_cnt); end
    n_checks++; if (ls_cnt !== 1) begin n_errors++; $display("FAIL line_ls_count: got %0d want 1", ls_cnt); end
    n_checks++; if (vs_cnt !== 0) begin n_errors++; $display("FAIL line_vsync: got %0d low ticks want 0", vs_cnt); end
    n_checks++; if (x639 !== 639) begin n_errors++; $display("FAIL line_posx_last: got %0d want 639", x639); end
    n_checks++; if (blank_posx !== 0) begin n_errors++; $display("FAIL line_hblank_posx: got %0d nonzero want 0", blank_posx); end
    tick();
    n_checks++;
    if ({bus_a.line_start, bus_a.frame_start, bus_a.posx, bus_a.posy} !== {1'b1, 1'b0, 10'd0, 9'd1}) begin
      n_errors++; $display("FAIL line_period: got ls=%b fs=%b posx=%0d posy=%0d want 1 0 0 1", bus_a.line_start, bus_a.frame_start, bus_a.posx, bus_a.posy);
    end
  endtask

  task automatic test_mid_reset;
    start_a();
    bus_a.pix_en = 1'b1;
    repeat (301) tick();
    n_checks++; if ({bus_a.posx, bus_a.active} !== {10'd300, 1'b1}) begin n_errors++; $display("FAIL midrst_a_pre: got posx=%0d act=%b want 300 1", bus_a.posx, bus_a.active); end
    #2 rst_a = 1'b0;
    #1;
    n_checks++;
    if ({bus_a.posx, bus_a.posy, bus_a.active, bus_a.hsync, bus_a.vsync} !== {10'd0, 9'd0, 1'b0, 1'b1, 1'b1}) begin
      n_errors++; $display("FAIL midrst_a_async: got posx=%0d posy=%0d act=%b hs=%b vs=%b want 0 0 0 1 1", bus_a.posx, bus_a.posy, bus_a.active, bus_a.hsync, bus_a.vsync);
    end
    #1 rst_a = 1'b1;
    tick();
    n_checks++;
    if ({bus_a.frame_start, bus_a.posx, bus_a.posy} !== {1'b1, 10'd0, 9'd0}) begin
      n_errors++; $display("FAIL midrst_a_restart: got fs=%b posx=%0d posy=%0d want 1 0 0", bus_a.frame_start, bus_a.posx, bus_a.posy);
    end
    start_b();
    bus_b.pix_en = 1'b1;
    repeat (36) tick();
    n_checks++; if ({bus_b.posx, bus_b.posy, bus_b.active} !== {10'd3, 9'd2, 1'b1}) begin n_errors++; $display("FAIL midrst_b_pre: got posx=%0d posy=%0d act=%b want 3 2 1", bus_b.posx, bus_b.posy, bus_b.active); end
    #2 rst_b = 1'b0;
    #1;
    n_checks++;
    if ({bus_b.posx, bus_b.posy, bus_b.active, bus_b.hsync, bus_b.vsync} !== {10'd0, 9'd0, 1'b0, 1'b1, 1'b1}) begin
      n_errors++; $display("FAIL midrst_b_async: got posx=%0d posy=%0d act=%b hs=%b vs=%b want 0 0 0 1 1", bus_b.posx, bus_b.posy, bus_b.active, bus_b.hsync, bus_b.vsync);
    end
    #1 rst_b = 1'b1;
    tick();
    n_checks++;
    if ({bus_b.frame_start, bus_b.line_start, bus_b.posx, bus_b.posy} !== {2'b11, 10'd0, 9'd0}) begin
      n_errors++; $display("FAIL midrst_b_restart: got fs=%b ls=%b posx=%0d posy=%0d want 1 1 0 0", bus_b.frame_start, bus_b.line_start, bus_b.posx, bus_b.posy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_first_edge();
    test_frame();
    test_pix_en_toggle();
    test_pipe_delay();
    test_line();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Raster timing generator for the 640x480 bitmap display path.
- Produces the pixel coordinates posx/posy that the bitmap memory controller turns into a screen address and pixel.
- Also produces hsync/vsync/active for the DAC/connector side, delayed to match the memory-read and pixel-decode latency downstream.
- Advances one pixel per pix_en tick, so it runs from the system clock with a pixel-rate enable.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, hsync width (ticks)
- H_BP, 48, horizontal back porch (ticks)
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active low)
- V_POL, 0, vsync active level (0 = active low)
- PIPE_DLY, 2, pix_en ticks by which hsync/vsync/active lag posx/posy (legal 0..4)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- pix_en  in  1  pixel-rate enable; raster advances on clk edges where pix_en=1
- posx  out  10  current column, 0..H_VIS-1; 0 outside the visible columns
- posy  out  9  current row, 0..V_VIS-1; 0 outside the visible rows
- hsync  out  1  horizontal sync at H_POL level, delayed by PIPE_DLY
- vsync  out  1  vertical sync at V_POL level, delayed by PIPE_DLY
- active  out  1  visible-region flag, delayed by PIPE_DLY
- line_start  out  1  one-clk strobe: raster entered hcnt=0
- frame_start  out  1  one-clk strobe: raster entered (hcnt,vcnt)=(0,0)

Behaviour:
- H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (525).
- hcnt and vcnt are each 10 bits.
- Reset (async, any time including mid-frame):
  - hcnt=H_TOTAL-1, vcnt=V_TOTAL-1.
  - posx=0, posy=0, active=0, line_start=0, frame_start=0.
  - hsync=!H_POL, vsync=!V_POL.
  - Whole delay pipeline loaded with inactive values (active=0, syncs inactive).
- Net effect of reset: the first pix_en after release lands on pixel (0,0).
- Counting, on each clk edge with pix_en=1:
  - hcnt wraps H_TOTAL-1 -> 0, else increments.
  - vcnt increments only on hcnt wrap; wraps V_TOTAL-1 -> 0.
- pix_en=0: counters, posx, posy, hsync, vsync, active and the delay pipeline all hold. line_start and frame_start go 0.
- Registered outputs are computed from the NEXT counter values, so they describe the pixel period that starts at that edge:
  - posx = hcnt_next when hcnt_next<H_VIS, else 0.
  - posy = vcnt_next[8:0] when vcnt_next<V_VIS, else 0.
  - line_start = (hcnt_next==0).
  - frame_start = (hcnt_next==0 && vcnt_next==0).
  - Both strobes last exactly one clk, even when pix_en stays high.
- Undelayed decode:
  - act0 = hcnt_next<H_VIS && vcnt_next<V_VIS.
  - hs0 asserted for H_VIS+H_FP <= hcnt_next < H_VIS+H_FP+H_SYNC (656..751 at defaults).
  - vs0 asserted for V_VIS+V_FP <= vcnt_next < V_VIS+V_FP+V_SYNC (490..491 at defaults).
  - vs0 changes at the hcnt=0 boundary only.
- Delay: act0/hs0/vs0 pass through a PIPE_DLY-stage shift register that shifts only on pix_en. PIPE_DLY=0 means the decode is registered alongside posx.
- posx=0 through horizontal blanking, so the downstream controller prefetches byte 0 of the next line during blanking. posy=0 through vertical blanking.
- Widths: H_VIS must be <=1024 and V_VIS <=512. A parameter check fails elaboration otherwise, and also when PIPE_DLY>4.

Decomposition:
- Shared package vga_pkg holds:
  - default 640x480@60 timing constants
  - HCNT_W=10, VCNT_W=10
  - derived H_TOTAL/V_TOTAL functions
- One sub-module, sync_delay: parameterized-depth, enable-gated, 3-bit-wide shift register with per-bit reset values. It is instantiated once for {active, hsync, vsync}.

Test Plan:
- Reset release, pix_en=1, PIPE_DLY=0 -> first edge: posx=0, posy=0, active=1, line_start=1 and frame_start=1 for exactly 1 clk; next edge posx=1, strobes 0.
- Line timing, defaults -> hsync low for exactly 96 ticks starting at posx-equivalent tick 656; line_start period 800 ticks; posx=0 and active=0 for ticks 640..799.
- Frame timing -> vsync low during lines 490..491 only (1600 ticks); frame_start period 420000 ticks; posy=0 for lines 480..524; posy=479 on last visible line.
- pix_en toggling 1,0,1,0 -> all outputs hold on pix_en=0 cycles; strobes are 1 clk wide; line period becomes 1600 clk.
- PIPE_DLY=2 -> active rises 2 pix_en ticks after posx=0/posy=0 of a frame; hsync edges lag the undelayed positions by 2 ticks.
- Assert rst_n low mid-line (posx=300, posy=200) with no clk edge -> outputs immediately posx=0, posy=0, active=0, hsync=1, vsync=1; after release the first pix_en gives frame_start=1.
